// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one 14-bit binary-to-4-digit-BCD converter among NREQ requesters.
// Define BCD_ARB_SAT_EN to clamp operands above 9999 to 9999 before conversion.
module bcd_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [14*NREQ-1:0]   req_bin,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_bcd,
  output logic                 rsp_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] prio_ptr;
  logic [IDW-1:0] grant_id;
  logic           grant_hit;
  logic           accept;
  logic [13:0]    grant_bin;
  logic [13:0]    op_bin;
  logic [IDW-1:0] op_id;
  logic           op_ovf;
  logic [13:0]    conv_in;
  logic [15:0]    conv_bcd;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[IDW-1:0];
  endfunction

  // Double dabble; digits above thousands shift out, which yields BCD of (bin mod 10000).
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'h0000, bin};
    for (int b = 0; b < 14; b++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  // Scan from the highest offset down so the closest eligible requester to prio_ptr wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(prio_ptr, i)]) begin
        grant_hit = 1'b1;
        grant_id  = rr_index(prio_ptr, i);
      end
    end
  end

  always_comb begin
    grant_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) grant_bin = req_bin[14*i +: 14];
    end
  end

  assign accept = (state == IDLE) && grant_hit && rst_n;

  assign op_ovf = (op_bin > 14'd9999);
`ifdef BCD_ARB_SAT_EN
  assign conv_in = op_ovf ? 14'd9999 : op_bin;
`else
  assign conv_in = op_bin;
`endif
  assign conv_bcd = bin_to_bcd(conv_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_hit) state_nxt = CONV;
      CONV:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is also gated by rst_n so it reads zero for the whole reset interval.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= '0;
      op_bin   <= '0;
      op_id    <= '0;
      rsp_bcd  <= 16'h0000;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        op_bin   <= grant_bin;
        op_id    <= grant_id;
        prio_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
      if (state == CONV) begin
        rsp_bcd <= conv_bcd;
        rsp_id  <= op_id;
        rsp_ovf <= op_ovf;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (honours BCD_ARB_SAT_EN).
module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

`ifdef BCD_ARB_SAT_EN
  localparam logic [15:0] BCD_16383 = 16'h9999;
  localparam logic [15:0] BCD_10000 = 16'h9999;
`else
  localparam logic [15:0] BCD_16383 = 16'h6383;
  localparam logic [15:0] BCD_10000 = 16'h0000;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [14*NREQ-1:0]   req_bin = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_bcd;
  logic                 rsp_ovf;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  // Reference model: pending transaction and its age, plus the round-robin pointer.
  int m_ptr = 0;
  int m_phase = 0;
  int m_id = 0;
  int m_val = 0;
  int m_last_acc = -1;
  int cyc = 0;
  int grant_log[$];
  int grant_cyc[$];
  logic [15:0] resp_log[$];

  bcd_conv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [14*NREQ-1:0] b, input logic rr);
    req_valid = v;
    req_bin   = b;
    rsp_ready = rr;
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int m;
`ifdef BCD_ARB_SAT_EN
    m = (v > 9999) ? 9999 : v;
`else
    m = v % 10000;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic int ref_grant();
    int j;
    for (int i = 0; i < NREQ; i++) begin
      j = (m_ptr + i) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [14*NREQ-1:0] pack4(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 9999;
      2:       return 10000;
      3:       return 16383;
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  // Called at a negedge after inputs are driven; checks, advances the model, waits one cycle.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = ref_grant();
    exp_rdy = '0;
    if (m_phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("req_ready", req_ready, exp_rdy);
    checkOutput("busy", busy, m_phase != 0);
    checkOutput("rsp_valid", rsp_valid, m_phase == 2);
    if (m_phase == 2) begin
      checkOutput("rsp_id", rsp_id, m_id);
      checkOutput("rsp_bcd", rsp_bcd, ref_bcd(m_val));
      checkOutput("rsp_ovf", rsp_ovf, m_val > 9999);
    end
    m_last_acc = -1;
    case (m_phase)
      0: if (g >= 0) begin
        m_phase = 1;
        m_id = g;
        m_val = int'(req_bin[14*g +: 14]);
        m_ptr = (g + 1) % NREQ;
        m_last_acc = g;
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end
      1: m_phase = 2;
      default: if (rsp_ready) begin
        resp_log.push_back(rsp_bcd);
        m_phase = 0;
      end
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic checkResetVals(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_id"}, rsp_id, 0);
    checkOutput({tag, "_rsp_bcd"}, rsp_bcd, 0);
    checkOutput({tag, "_rsp_ovf"}, rsp_ovf, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic modelReset();
    m_ptr = 0;
    m_phase = 0;
    m_last_acc = -1;
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetVals("reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runOne(input string tag, input int id, input int val,
                        input logic [15:0] exp_bcd, input logic exp_ovf);
    logic [14*NREQ-1:0] b;
    b = '0;
    b[14*id +: 14] = 14'(val);
    applyStimulus(NREQ'(1) << id, b, 1'b1);
    step();
    applyStimulus('0, b, 1'b1);
    step();
    checkOutput({tag, "_valid"}, rsp_valid, 1);
    checkOutput({tag, "_bcd"}, rsp_bcd, exp_bcd);
    checkOutput({tag, "_ovf"}, rsp_ovf, exp_ovf);
    checkOutput({tag, "_id"}, rsp_id, id);
    step();
    checkOutput({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int rr_ids[5];
    logic [15:0] rr_bcd[5];
    logic [NREQ-1:0] v;
    logic [14*NREQ-1:0] bb;
    rr_ids = '{0, 1, 2, 3, 0};
    rr_bcd = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010};

    #2;
    doReset();

    runOne("single", 0, 1234, 16'h1234, 1'b0);

    doReset();
    grant_log.delete();
    grant_cyc.delete();
    resp_log.delete();
    applyStimulus(4'b1111, pack4(10, 20, 30, 40), 1'b1);
    for (int n = 0; n < 15; n++) step();
    checkOutput("rr_grants", grant_log.size(), 5);
    checkOutput("rr_resps", resp_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) checkOutput("rr_order", grant_log[i], rr_ids[i]);
      if (i < resp_log.size()) checkOutput("rr_bcd", resp_log[i], rr_bcd[i]);
      if (i > 0 && i < grant_cyc.size()) checkOutput("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end

    doReset();
    applyStimulus(4'b0011, pack4(9999, 55, 0, 0), 1'b0);
    step();
    applyStimulus(4'b0010, pack4(9999, 55, 0, 0), 1'b0);
    step();
    for (int n = 0; n < 10; n++) begin
      checkOutput("bp_valid", rsp_valid, 1);
      checkOutput("bp_bcd", rsp_bcd, 16'h9999);
      checkOutput("bp_ready", req_ready, 0);
      step();
    end
    applyStimulus(4'b0010, pack4(9999, 55, 0, 0), 1'b1);
    step();
    applyStimulus(4'b0010, pack4(9999, 55, 0, 0), 1'b0);
    #1;
    checkOutput("bp_next_grant", req_ready, 4'b0010);
    step();
    applyStimulus('0, pack4(9999, 55, 0, 0), 1'b1);
    for (int n = 0; n < 3; n++) step();

    doReset();
    runOne("ovf16383", 2, 16383, BCD_16383, 1'b1);
    runOne("ovf10000", 3, 10000, BCD_10000, 1'b1);
    runOne("zero", 1, 0, 16'h0000, 1'b0);
    runOne("max9999", 2, 9999, 16'h9999, 1'b0);

    doReset();
    applyStimulus(4'b1111, pack4(111, 222, 333, 444), 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetVals("midrst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_first_grant", req_ready, 4'b0001);
    checkOutput("midrst_no_rsp", rsp_valid, 0);
    for (int n = 0; n < 6; n++) step();

    doReset();
    for (int n = 0; n < 400; n++) begin
      v = req_valid;
      bb = req_bin;
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && i != m_last_acc) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else begin
          v[i] = ($urandom_range(0, 2) == 0);
          bb[14*i +: 14] = 14'(rand_operand());
        end
      end
      applyStimulus(v, bb, $urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
